// File: rtl/lfcg_pkg.sv
// Low-frequency clock generator: shared types and default widths.
// Imported by the core and its half-period counter.
package lfcg_pkg;

    localparam int LFCG_CNT_W  = 32;
    localparam int LFCG_NCYC_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } lfcg_state_t;

endpackage

// File: rtl/lfcg_half_period_ctr.sv
// Half-period counter: counts 0..div-1 while enabled and flags the wrap.
// div is expected to be at least 1; the core guarantees this.
module lfcg_half_period_ctr
    import lfcg_pkg::*;
#(
    parameter int CNT_W = LFCG_CNT_W
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    assign wrap = en && (cnt == div - CNT_W'(1));

    // Count while enabled, return to 0 on wrap, hold cleared otherwise.
    always_ff @(posedge ACLK) begin
        if (ARESET || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lfcg_core.sv
// Low-frequency clock generator core: run FSM, clk_out toggle, period count.
// All outputs come straight from flops.
module lfcg_core
    import lfcg_pkg::*;
#(
    parameter int CNT_W  = LFCG_CNT_W,
    parameter int NCYC_W = LFCG_NCYC_W
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              ctrl_en,
    input  logic              ctrl_start,
    input  logic [CNT_W-1:0]  ctrl_div,
    input  logic [NCYC_W-1:0] ctrl_ncyc,
    output logic              clk_out,
    output logic              tick,
    output logic              busy,
    output logic              done,
    output logic [NCYC_W-1:0] cyc_cnt
);

    localparam logic [NCYC_W-1:0] CYC_MAX = '1;

    lfcg_state_t       state;
    lfcg_state_t       state_nx;
    logic [CNT_W-1:0]  div_q;
    logic [NCYC_W-1:0] ncyc_q;
    logic              wrap;
    logic              go;
    logic              last_fall;

    assign go = ctrl_start && ctrl_en;

    // The falling edge that completes the final requested period.
    assign last_fall = wrap && clk_out && (ncyc_q != '0)
                       && (cyc_cnt + NCYC_W'(1) == ncyc_q);

    lfcg_half_period_ctr #(
        .CNT_W(CNT_W)
    ) u_hp_ctr (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .clr   (state != RUN),
        .en    (state == RUN),
        .div   (div_q),
        .wrap  (wrap)
    );

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; dropping enable wins over completion.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go) state_nx = RUN;
            RUN: begin
                if (!ctrl_en) begin
                    state_nx = IDLE;
                end else if (last_fall) begin
                    state_nx = FINISH;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Latched run settings, clk_out toggle, tick/busy/done and period count.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cyc_cnt <= '0;
            div_q   <= '0;
            ncyc_q  <= '0;
        end else begin
            tick <= 1'b0;
            busy <= (state_nx == RUN);
            done <= (state_nx == FINISH);
            unique case (state)
                IDLE: begin
                    clk_out <= 1'b0;
                    if (go) begin
                        div_q   <= (ctrl_div == '0) ? CNT_W'(1) : ctrl_div;
                        ncyc_q  <= ctrl_ncyc;
                        cyc_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!ctrl_en) begin
                        clk_out <= 1'b0;
                    end else if (wrap) begin
                        clk_out <= ~clk_out;
                        tick    <= ~clk_out;
                        if (clk_out && cyc_cnt != CYC_MAX) begin
                            cyc_cnt <= cyc_cnt + NCYC_W'(1);
                        end
                    end
                end
                FINISH:  clk_out <= 1'b0;
                default: clk_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lfcg_core.sv
// Bench for lfcg_core: per-cycle model, scenario table and corner sequences.
// Narrow widths so cyc_cnt saturation is reachable quickly.
module tb_lfcg_core;

    localparam int CW   = 8;
    localparam int NW   = 4;
    localparam int CMAX = (1 << NW) - 1;

    logic          ACLK       = 1'b0;
    logic          ARESET     = 1'b1;
    logic          ctrl_en    = 1'b0;
    logic          ctrl_start = 1'b0;
    logic [CW-1:0] ctrl_div   = '0;
    logic [NW-1:0] ctrl_ncyc  = '0;
    logic          clk_out;
    logic          tick;
    logic          busy;
    logic          done;
    logic [NW-1:0] cyc_cnt;

    lfcg_core #(
        .CNT_W (CW),
        .NCYC_W(NW)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ctrl_en   (ctrl_en),
        .ctrl_start(ctrl_start),
        .ctrl_div  (ctrl_div),
        .ctrl_ncyc (ctrl_ncyc),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .cyc_cnt   (cyc_cnt)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc_no = 0;
    int tk_cnt = 0;
    int dn_cnt = 0;

    // Reference: mode 0 idle, 1 run, 2 finish; t = cycles since run entry.
    int m_mode = 0;
    int m_t    = 0;
    int m_d    = 1;
    int m_n    = 0;
    int m_held = 0;

    function automatic int periods(input int t, input int d);
        int p;
        p = t / (2 * d);
        return (p > CMAX) ? CMAX : p;
    endfunction

    function automatic logic [31:0] model_vec();
        logic e_clk;
        logic e_tick;
        logic e_busy;
        logic e_done;
        int   e_cyc;
        e_clk  = 1'b0;
        e_tick = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_cyc  = m_held;
        if (m_mode == 1) begin
            e_busy = 1'b1;
            e_clk  = ((m_t / m_d) % 2) == 1;
            e_tick = e_clk && ((m_t % m_d) == 0);
            e_cyc  = periods(m_t, m_d);
        end else if (m_mode == 2) begin
            e_done = 1'b1;
        end
        return {e_clk, e_tick, e_busy, e_done, 28'(e_cyc)};
    endfunction

    function automatic void model_update();
        if (ARESET) begin
            m_mode = 0;
            m_held = 0;
        end else begin
            case (m_mode)
                0: if (ctrl_start && ctrl_en) begin
                    m_mode = 1;
                    m_t    = 0;
                    m_d    = (ctrl_div == '0) ? 1 : int'(ctrl_div);
                    m_n    = int'(ctrl_ncyc);
                end
                1: if (!ctrl_en) begin
                    m_held = periods(m_t, m_d);
                    m_mode = 0;
                end else begin
                    m_t = m_t + 1;
                    if (m_n != 0 && m_t == 2 * m_d * m_n) begin
                        m_mode = 2;
                        m_held = m_n;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        model_update();
        #1;
        cyc_no++;
        check($sformatf("cycle%0d {clk,tick,busy,done,cyc}", cyc_no),
              {clk_out, tick, busy, done, 28'(cyc_cnt)}, model_vec());
        tk_cnt += int'(tick);
        dn_cnt += int'(done);
    endtask

    task automatic start_run(input int d, input int n);
        ctrl_div   = CW'(d);
        ctrl_ncyc  = NW'(n);
        ctrl_en    = 1'b1;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        tk_cnt     = 0;
        dn_cnt     = 0;
    endtask

    typedef struct {
        int div;
        int ncyc;
        int cycles;
        int ticks;
        int dones;
        int cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [14:1] clk_h, tick_h, done_h, busy_h;
        logic [14:1] e_clk, e_tick, e_done, e_busy;
        logic [NW-1:0] cyc13;
        logic hi;
        int done_at;

        vecs[0] = '{div: 0, ncyc: 4,  cycles: 12, ticks: 4,  dones: 1, cyc: 4};
        vecs[1] = '{div: 3, ncyc: 2,  cycles: 16, ticks: 2,  dones: 1, cyc: 2};
        vecs[2] = '{div: 2, ncyc: 0,  cycles: 40, ticks: 10, dones: 0, cyc: 10};
        vecs[3] = '{div: 1, ncyc: 0,  cycles: 40, ticks: 20, dones: 0, cyc: 15};
        vecs[4] = '{div: 1, ncyc: 15, cycles: 40, ticks: 15, dones: 1, cyc: 15};
        vecs[5] = '{div: 5, ncyc: 1,  cycles: 15, ticks: 1,  dones: 1, cyc: 1};

        // Reset state.
        ARESET = 1'b1;
        step();
        step();
        check("reset_outputs", 32'({clk_out, tick, busy, done, cyc_cnt}), 32'd0);
        ARESET = 1'b0;
        step();

        // Exact waveform of a div=3, ncyc=2 run.
        start_run(3, 2);
        cyc13 = '0;
        for (int c = 1; c <= 14; c++) begin
            clk_h[c]  = clk_out;
            tick_h[c] = tick;
            done_h[c] = done;
            busy_h[c] = busy;
            if (c == 13) cyc13 = cyc_cnt;
            e_clk[c]  = (c >= 4 && c <= 6) || (c >= 10 && c <= 12);
            e_tick[c] = (c == 4) || (c == 10);
            e_done[c] = (c == 13);
            e_busy[c] = (c <= 12);
            step();
        end
        check("div3_clk_wave", 32'(clk_h), 32'(e_clk));
        check("div3_tick_cycles", 32'(tick_h), 32'(e_tick));
        check("div3_done_cycle", 32'(done_h), 32'(e_done));
        check("div3_busy_cycles", 32'(busy_h), 32'(e_busy));
        check("div3_cyc_cnt", 32'(cyc13), 32'd2);

        // Scenario table: counted runs, free runs with abort, saturation.
        for (int i = 0; i < 6; i++) begin
            start_run(vecs[i].div, vecs[i].ncyc);
            for (int k = 0; k < vecs[i].cycles; k++) step();
            check($sformatf("vec%0d_ticks", i), 32'(tk_cnt), 32'(vecs[i].ticks));
            check($sformatf("vec%0d_dones", i), 32'(dn_cnt), 32'(vecs[i].dones));
            ctrl_en = 1'b0;
            step();
            check($sformatf("vec%0d_stop", i), 32'({clk_out, busy, done}), 32'd0);
            step();
            check($sformatf("vec%0d_cyc", i), 32'(cyc_cnt), 32'(vecs[i].cyc));
            ctrl_en = 1'b1;
        end

        // Second start mid-run with new settings is ignored.
        start_run(3, 2);
        done_at = 0;
        for (int c = 2; c <= 20; c++) begin
            if (c == 6) begin
                ctrl_div   = CW'(7);
                ctrl_ncyc  = NW'(5);
                ctrl_start = 1'b1;
            end
            step();
            ctrl_start = 1'b0;
            if (done && done_at == 0) done_at = c;
        end
        check("restart_ticks", 32'(tk_cnt), 32'd2);
        check("restart_done_cycle", 32'(done_at), 32'd13);
        check("restart_cyc", 32'(cyc_cnt), 32'd2);

        // Reset in the middle of a div=4 run, then a clean run.
        start_run(4, 0);
        for (int k = 0; k < 4; k++) step();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        check("midreset_outputs",
              32'({clk_out, tick, busy, done, cyc_cnt}), 32'd0);
        start_run(4, 1);
        for (int k = 0; k < 10; k++) step();
        check("after_reset_done", 32'(dn_cnt), 32'd1);
        check("after_reset_ticks", 32'(tk_cnt), 32'd1);

        // Start while disabled is ignored.
        ctrl_en    = 1'b0;
        ctrl_start = 1'b1;
        ctrl_div   = CW'(1);
        step();
        ctrl_start = 1'b0;
        hi = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            hi = hi | busy | clk_out;
        end
        check("disabled_start", 32'(hi), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            ARESET     = ($urandom_range(0, 99) == 0);
            ctrl_en    = ($urandom_range(0, 39) != 0);
            ctrl_start = ($urandom_range(0, 5) == 0);
            ctrl_div   = CW'($urandom_range(0, 5));
            ctrl_ncyc  = NW'($urandom_range(0, 4));
            step();
            if (tick && done) check("tick_done_overlap", 32'd1, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
